// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave register file; NUM_REGS software-visible 32-bit registers exported as a flat vector.
// Latency: B response and RDATA are valid 1 cycle after the completing handshake; REG_WR_PULSE is valid on that same cycle.
// Backpressure: BVALID/RVALID, BRESP/RRESP and RDATA are held until BREADY/RREADY; the READYs stay low meanwhile.
//
// Ports:
//   ACLK, ARESET         clock (rising edge) and synchronous active-high reset
//   S_AXI_AW*/W*/B*      write address, write data and write response channels
//   S_AXI_AR*/R*         read address and read data channels (independent of the write side)
//   REG_OUT              register i at [32*i+31:32*i]
//   REG_WR_PULSE         bit i is high for one cycle after register i is written
//
// Optional build macro AXIL_SLVERR_EN: out-of-range accesses respond SLVERR (2'b10)
// instead of OKAY. Register side effects are the same in both builds.
module axil_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REG_OUT,
  output logic [NUM_REGS-1:0]            REG_WR_PULSE
);

  localparam int IDXW  = ADDR_WIDTH - 2;
  localparam int NBYTE = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

  // ---------------- write side ----------------
  wstate_t               wstate, wstate_nxt;
  logic                  aw_hs, w_hs, commit;
  logic [ADDR_WIDTH-1:0] aw_addr_q, cmt_addr;
  logic [DATA_WIDTH-1:0] w_data_q, cmt_data;
  logic [NBYTE-1:0]      w_strb_q, cmt_strb;
  logic [IDXW-1:0]       cmt_idx;
  logic [NUM_REGS-1:0]   cmt_hit;

  assign S_AXI_AWREADY = (wstate == W_IDLE) || (wstate == W_WAIT_ADDR);
  assign S_AXI_WREADY  = (wstate == W_IDLE) || (wstate == W_WAIT_DATA);
  assign S_AXI_BVALID  = (wstate == W_RESP);

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;

  always_comb begin
    wstate_nxt = wstate;
    commit     = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit     = 1'b1;
          wstate_nxt = W_RESP;
        end else if (aw_hs) begin
          wstate_nxt = W_WAIT_DATA;
        end else if (w_hs) begin
          wstate_nxt = W_WAIT_ADDR;
        end
      end
      W_WAIT_DATA: begin
        if (w_hs) begin
          commit     = 1'b1;
          wstate_nxt = W_RESP;
        end
      end
      W_WAIT_ADDR: begin
        if (aw_hs) begin
          commit     = 1'b1;
          wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  // Whichever half arrived first was latched; the other is taken live off the bus.
  assign cmt_addr = (wstate == W_WAIT_DATA) ? aw_addr_q : S_AXI_AWADDR;
  assign cmt_data = (wstate == W_WAIT_ADDR) ? w_data_q  : S_AXI_WDATA;
  assign cmt_strb = (wstate == W_WAIT_ADDR) ? w_strb_q  : S_AXI_WSTRB;
  assign cmt_idx  = cmt_addr[ADDR_WIDTH-1:2];

  // One-hot target; all zero for an out-of-range index, so such writes touch nothing.
  always_comb begin
    cmt_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cmt_hit[i] = commit && (cmt_idx == IDXW'(i));
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate       <= W_IDLE;
      aw_addr_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      regs         <= '0;
      REG_WR_PULSE <= '0;
      S_AXI_BRESP  <= 2'b00;
    end else begin
      wstate <= wstate_nxt;
      if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      REG_WR_PULSE <= cmt_hit;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (cmt_hit[i]) begin
          for (int k = 0; k < NBYTE; k++) begin
            if (cmt_strb[k]) regs[i][8*k +: 8] <= cmt_data[8*k +: 8];
          end
        end
      end
      if (commit) begin
`ifdef AXIL_SLVERR_EN
        S_AXI_BRESP <= (|cmt_hit) ? 2'b00 : 2'b10;
`else
        S_AXI_BRESP <= 2'b00;
`endif
      end
    end
  end

  // ---------------- read side ----------------
  rstate_t               rstate, rstate_nxt;
  logic                  ar_hs, rd_hit;
  logic [IDXW-1:0]       rd_idx;
  logic [DATA_WIDTH-1:0] rd_val;

  assign S_AXI_ARREADY = (rstate == R_IDLE);
  assign S_AXI_RVALID  = (rstate == R_DATA);
  assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
  assign rd_idx        = S_AXI_ARADDR[ADDR_WIDTH-1:2];

  // Reads sample regs before this edge's write update lands, so a same-edge
  // read of a register being written returns the old value.
  always_comb begin
    rd_val = '0;
    rd_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDXW'(i)) begin
        rd_val = regs[i];
        rd_hit = 1'b1;
      end
    end
  end

  always_comb begin
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs) rstate_nxt = R_DATA;
      R_DATA:  if (S_AXI_RREADY) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate      <= R_IDLE;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= 2'b00;
    end else begin
      rstate <= rstate_nxt;
      if (ar_hs) begin
        S_AXI_RDATA <= rd_val;
`ifdef AXIL_SLVERR_EN
        S_AXI_RRESP <= rd_hit ? 2'b00 : 2'b10;
`else
        S_AXI_RRESP <= 2'b00;
`endif
      end
    end
  end

  assign REG_OUT = regs;

  // Protection bits and byte-lane address bits carry no meaning here.
  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], rd_hit};

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
AXI4-Lite slave register file. It is the downstream consumer of the subsystem's AXI4-Lite master VIP traffic, terminating single-beat writes and reads on a bank of software-visible 32-bit registers. Register contents are exported to subsystem logic as a flat vector, with a per-register write-strobe pulse. Write and read channels run independently and concurrently.

Parameters:
DATA_WIDTH, 32, AXI data width; fixed at 32 (WSTRB is 4 bits).
ADDR_WIDTH, 5, AXI byte-address width; register index = ADDR[ADDR_WIDTH-1:2].
NUM_REGS, 4, implemented registers, index 0..NUM_REGS-1; must satisfy NUM_REGS <= 2**(ADDR_WIDTH-2).

Ports:
ACLK  in  1  clock; all logic on rising edge.
ARESET  in  1  synchronous, active-high reset.
S_AXI_AWADDR  in  ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  accepted, ignored.
S_AXI_AWVALID  in  1  write-address valid.
S_AXI_AWREADY  out  1  write-address ready.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID  in  1  write-data valid.
S_AXI_WREADY  out  1  write-data ready.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID  out  1  write-response valid.
S_AXI_BREADY  in  1  write-response ready.
S_AXI_ARADDR  in  ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  accepted, ignored.
S_AXI_ARVALID  in  1  read-address valid.
S_AXI_ARREADY  out  1  read-address ready.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID  out  1  read-data valid.
S_AXI_RREADY  in  1  read-data ready.
REG_OUT  out  NUM_REGS*32  register contents; reg i at [32*i+31:32*i].
REG_WR_PULSE  out  NUM_REGS  one-cycle pulse on the cycle after reg i is written.

Behaviour:
- Reset (ARESET=1 at a clock edge): all registers 0; write FSM W_IDLE, read FSM R_IDLE; BVALID=0, RVALID=0, RDATA=0, BRESP=RRESP=2'b00, REG_WR_PULSE=0. Reset mid-transaction drops any captured AW/W/AR and any pending B/R response; no register is modified by the aborted transaction.
- READY outputs are decoded from registered state only, never from VALID inputs.
- Write FSM:
  - W_IDLE: AWREADY=1, WREADY=1. AW and W handshake on the same edge -> commit, go W_RESP. AW only -> latch address, go W_WAIT_DATA. W only -> latch data/strobe, go W_WAIT_ADDR.
  - W_WAIT_DATA: AWREADY=0, WREADY=1. On W handshake -> commit, go W_RESP.
  - W_WAIT_ADDR: AWREADY=1, WREADY=0. On AW handshake -> commit, go W_RESP.
  - W_RESP: BVALID=1, both READYs 0. Hold BVALID and BRESP until BREADY. On handshake go W_IDLE.
- Commit: on the edge that completes the second handshake, byte k of register[idx] <= WDATA byte k wherever WSTRB[k]=1. REG_WR_PULSE[idx]=1 for exactly the following cycle. BVALID rises on that same following cycle (1-cycle latency).
- Read FSM:
  - R_IDLE: ARREADY=1. On AR handshake, RDATA <= register[idx]; go R_DATA.
  - R_DATA: RVALID=1, ARREADY=0. RDATA and RRESP are stable until RREADY. On handshake go R_IDLE.
  - RVALID rises 1 cycle after the AR handshake.
- Address decode: ADDR[1:0] is ignored. Out of range means idx >= NUM_REGS. An out-of-range write modifies nothing and produces no pulse. An out-of-range read returns 0.
- Simultaneous read and write commit to the same register on one edge: the read returns the pre-write value.
- Back-to-back throughput: maximum one write per 2 cycles and one read per 2 cycles.

Optional Feature:
AXIL_SLVERR_EN
- Defined: an out-of-range access returns BRESP/RRESP = 2'b10 (SLVERR); out-of-range read data is 0.
- Undefined: all responses are OKAY (2'b00).
- Register side effects are identical in both builds.

Test Plan:
1. Write 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC, then read all four back -> RDATA = 0x1, 0x2, 0x3, 0x4; every BRESP and RRESP = OKAY; REG_WR_PULSE pulses bits 0..3 in order, one per write.
2. Reg0 = 0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 -> reg0 reads 0xFF34FF78.
3. AWVALID asserted 3 cycles before WVALID, then a second write with W 3 cycles before AW -> both commit; BVALID rises exactly 1 cycle after the later handshake.
4. BREADY and RREADY held low for 5 cycles -> BVALID/RVALID, BRESP/RRESP and RDATA are held stable; AWREADY, WREADY and ARREADY stay 0 until the response handshake.
5. Write 0xDEAD to 0x10 and read 0x14 -> no register changes; RDATA=0; responses are SLVERR with AXIL_SLVERR_EN defined, OKAY without it.
6. ARESET asserted in W_WAIT_DATA with reg1=0x5 -> after reset all registers 0 and BVALID=0; the subsequent W beat alone is latched and no commit occurs until a new AW arrives.
